// File: rtl/reg_bank_arbiter.sv
// reg_bank_arbiter: round-robin write arbiter and sequencer for a small bank
// of registers shared by NREQ requesters, plus a registered read port.
//
// Each transaction takes two cycles: IDLE picks a winner and captures its
// address/data, and COMMIT writes the bank and raises that requester's ack
// for one cycle.
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous, active-high reset
//   req      per-requester write request, held until ack
//   wr_addr  packed write addresses, requester i at [i*AW +: AW]
//   wr_data  packed write data, requester i at [i*WIDTH +: WIDTH]
//   lock     per-requester priority hold (only used with ARB_LOCK_EN)
//   ack      registered one-hot write-complete pulse
//   busy     registered, high while in COMMIT
//   rd_addr  read address
//   rd_data  registered read data (bank[rd_addr], one cycle latency)
//
// Build option:
//   ARB_LOCK_EN  when defined, a committing requester with lock high keeps
//                the round-robin pointer on itself instead of advancing it.

module reg_bank_arbiter #(
  parameter  int unsigned NREQ  = 4,
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned NREGS = 4,
  localparam int unsigned AW    = $clog2(NREGS),
  localparam int unsigned IW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*AW-1:0]    wr_addr,
  input  logic [NREQ*WIDTH-1:0] wr_data,
  input  logic [NREQ-1:0]       lock,
  output logic [NREQ-1:0]       ack,
  output logic                  busy,
  input  logic [AW-1:0]         rd_addr,
  output logic [WIDTH-1:0]      rd_data
);

  typedef enum logic {
    IDLE   = 1'b0,
    COMMIT = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [IW-1:0]     cap_idx_q, cap_idx_d;
  logic [AW-1:0]     cap_addr_q, cap_addr_d;
  logic [WIDTH-1:0]  cap_data_q, cap_data_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic              busy_q, busy_d;
  logic [WIDTH-1:0]  rd_data_q, rd_data_d;
  logic [WIDTH-1:0]  bank_q [NREGS];
  logic [WIDTH-1:0]  bank_d [NREGS];

  logic [NREQ-1:0]   eff_c;
  logic [IW-1:0]     win_c;
  logic [IW-1:0]     ptr_adv_c;

  // First set bit of v at or after p, wrapping. Scanning downward lets the
  // smallest offset from p be the last (winning) assignment.
  function automatic logic [IW-1:0] rr_pick(input logic [NREQ-1:0] v,
                                            input logic [IW-1:0]   p);
    int unsigned c;
    rr_pick = p;
    for (int i = int'(NREQ) - 1; i >= 0; i--) begin
      c = 32'(p) + unsigned'(i);
      if (c >= NREQ) c = c - NREQ;
      if (v[IW'(c)]) rr_pick = IW'(c);
    end
  endfunction

  // A requester is ignored during its own ack cycle.
  assign eff_c = req & ~ack_q;
  assign win_c = rr_pick(eff_c, ptr_q);

  // Pointer moves just past the requester that committed.
  assign ptr_adv_c = (cap_idx_q == IW'(NREQ - 1)) ? '0 : cap_idx_q + IW'(1);

  // Next-state, capture, bank write and output logic.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cap_idx_d  = cap_idx_q;
    cap_addr_d = cap_addr_q;
    cap_data_d = cap_data_q;
    ack_d      = '0;
    busy_d     = 1'b0;
    bank_d     = bank_q;
    rd_data_d  = bank_q[rd_addr];

    unique case (state_q)
      IDLE: begin
        if (eff_c != '0) begin
          cap_idx_d  = win_c;
          cap_addr_d = wr_addr[win_c*AW +: AW];
          cap_data_d = wr_data[win_c*WIDTH +: WIDTH];
          busy_d     = 1'b1;
          state_d    = COMMIT;
        end
      end
      COMMIT: begin
        bank_d[cap_addr_q] = cap_data_q;
        ack_d[cap_idx_q]   = 1'b1;
`ifdef ARB_LOCK_EN
        ptr_d = lock[cap_idx_q] ? cap_idx_q : ptr_adv_c;
`else
        ptr_d = ptr_adv_c;
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifndef ARB_LOCK_EN
  // lock is part of the port list in every build but only steers ptr with
  // the lock option enabled.
  logic unused_lock;
  assign unused_lock = ^lock;
`endif

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      cap_idx_q  <= '0;
      cap_addr_q <= '0;
      cap_data_q <= '0;
      ack_q      <= '0;
      busy_q     <= 1'b0;
      rd_data_q  <= '0;
      for (int i = 0; i < int'(NREGS); i++) bank_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cap_idx_q  <= cap_idx_d;
      cap_addr_q <= cap_addr_d;
      cap_data_q <= cap_data_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
      rd_data_q  <= rd_data_d;
      for (int i = 0; i < int'(NREGS); i++) bank_q[i] <= bank_d[i];
    end
  end

  assign ack     = ack_q;
  assign busy    = busy_q;
  assign rd_data = rd_data_q;

endmodule

// File: tb/tb_reg_bank_arbiter.sv
module tb_reg_bank_arbiter;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned NREGS = 4;
  localparam int unsigned AW    = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [NREQ*AW-1:0]    wr_addr;
  logic [NREQ*WIDTH-1:0] wr_data;
  logic [NREQ-1:0]       lock;
  logic [NREQ-1:0]       ack;
  logic                  busy;
  logic [AW-1:0]         rd_addr;
  logic [WIDTH-1:0]      rd_data;

  int checks = 0;
  int errors = 0;

  reg_bank_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .NREGS(NREGS)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .lock    (lock),
    .ack     (ack),
    .busy    (busy),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are driven and outputs sampled here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wr(input int i, input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    wr_addr[i*AW +: AW]       = a;
    wr_data[i*WIDTH +: WIDTH] = d;
  endtask

  task automatic read_chk(input string tag, input logic [AW-1:0] a, input logic [WIDTH-1:0] exp);
    rd_addr = a;
    step();
    check(tag, 32'(rd_data), 32'(exp));
  endtask

  int exp_rr [5] = '{0, 1, 2, 3, 0};
  int exp_alt [4] = '{0, 1, 0, 1};

  initial begin
    rst = 1'b1; req = '0; wr_addr = '0; wr_data = '0; lock = '0; rd_addr = '0;
    step(); step();
    rst = 1'b0;
    check("rst_ack", 32'(ack), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_rd", 32'(rd_data), 32'h0);

    // Single write: requester 0 writes 0xA5 to address 2.
    set_wr(0, 2'd2, 8'hA5);
    rd_addr = 2'd2;
    req = 4'b0001;
    step();
    check("sw_busy_k", 32'(busy), 32'h1);
    check("sw_ack_k", 32'(ack), 32'h0);
    step();
    check("sw_busy_k1", 32'(busy), 32'h0);
    check("sw_ack_k1", 32'(ack), 32'h1);
    check("sw_rd_old", 32'(rd_data), 32'h0);
    req = '0;
    step();
    check("sw_ack_k2", 32'(ack), 32'h0);
    check("sw_rd_new", 32'(rd_data), 32'hA5);

    // Reset in the middle of a COMMIT: no ack, bank fully cleared.
    set_wr(0, 2'd3, 8'h5A);
    req = 4'b0001;
    step();
    check("rc_busy", 32'(busy), 32'h1);
    rst = 1'b1;
    req = '0;
    step();
    check("rc_ack_in_rst", 32'(ack), 32'h0);
    step();
    rst = 1'b0;
    check("rc_ack", 32'(ack), 32'h0);
    check("rc_busy0", 32'(busy), 32'h0);
    check("rc_rd", 32'(rd_data), 32'h0);
    step();
    check("rc_ack_after", 32'(ack), 32'h0);
    for (int a = 0; a < 4; a++) read_chk($sformatf("rc_bank%0d", a), AW'(a), 8'h00);

    // Round-robin with all four requesting continuously.
    for (int i = 0; i < 4; i++) set_wr(i, AW'(i), 8'hC0 | 8'(i));
    req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      step();
      check($sformatf("rr_busy%0d", t), 32'(busy), 32'h1);
      check($sformatf("rr_noack%0d", t), 32'(ack), 32'h0);
      step();
      check($sformatf("rr_ack%0d", t), 32'(ack), 32'(4'b0001 << exp_rr[t]));
      if (t == 4) req = '0;
    end
    for (int a = 0; a < 4; a++) read_chk($sformatf("rr_bank%0d", a), AW'(a), 8'hC0 | 8'(a));
    // ptr now 1

    // Requester 2 wins, then 0101 wraps the pointer to requester 0 first.
    set_wr(0, 2'd0, 8'h77);
    set_wr(2, 2'd2, 8'h88);
    req = 4'b0100;
    step();
    step();
    check("ct_ack2", 32'(ack), 32'h4);
    req = '0;
    step();
    req = 4'b0101;
    step();
    check("ct_busy0", 32'(busy), 32'h1);
    wr_data[0 +: WIDTH] = 8'hFF;   // must not affect the captured write
    step();
    check("ct_ack0", 32'(ack), 32'h1);
    step();
    check("ct_busy2", 32'(busy), 32'h1);
    req = '0;                      // drop during COMMIT, write still completes
    step();
    check("ct_ack2b", 32'(ack), 32'h4);
    step();
    check("ct_idle_ack", 32'(ack), 32'h0);
    check("ct_idle_busy", 32'(busy), 32'h0);
    read_chk("ct_bank0", 2'd0, 8'h77);
    read_chk("ct_bank2", 2'd2, 8'h88);
    // ptr now 3

    // Read-during-write on address 1.
    set_wr(1, 2'd1, 8'h11);
    req = 4'b0010;
    step();
    step();
    check("rw_ack_a", 32'(ack), 32'h2);
    req = '0;
    step();
    set_wr(1, 2'd1, 8'h22);
    rd_addr = 2'd1;
    req = 4'b0010;
    step();
    check("rw_rd_cap", 32'(rd_data), 32'h11);
    step();
    check("rw_ack_b", 32'(ack), 32'h2);
    check("rw_rd_old", 32'(rd_data), 32'h11);
    req = '0;
    step();
    check("rw_rd_new", 32'(rd_data), 32'h22);
    // ptr now 2

    // req=0011 with lock=0001. The locked requester is masked during its
    // own ack cycle, so requester 1 still gets the next slot: grants alternate.
    lock = 4'b0001;
    req  = 4'b0011;
    for (int t = 0; t < 4; t++) begin
      step();
      step();
      check($sformatf("lk_ack%0d", t), 32'(ack), 32'(4'b0001 << exp_alt[t]));
    end
    lock = '0;
    req  = '0;
    step();
    step();
    check("end_ack", 32'(ack), 32'h0);
    check("end_busy", 32'(busy), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
